// File: rtl/packed_slice_pkg.sv
// Shared types for the packed slice gather block: operating mode, gather FSM
// states and the slice offset helper used by the lanes and the merge logic.
package packed_slice_pkg;

    typedef enum logic {
        MODE_IMMEDIATE = 1'b0,
        MODE_ATOMIC    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_GATHER  = 1'b0,
        ST_PUBLISH = 1'b1
    } state_e;

    function automatic int slice_lsb(input int k, input int cw);
        return k * cw;
    endfunction

endpackage

// File: rtl/packed_slice_gather_lane.sv
// One producer lane: shadow slice register, pending flag and write-ready.
// Ports: valid_i/data_i (producer), gather_i/clear_i (from FSM), ready_o,
//        accept_o, pending_o, pending_nxt_o, shadow_nxt_o (to merge logic).
module slice_lane #(
    parameter int            CW        = 4,
    parameter bit            ATOMIC    = 1'b0,
    parameter logic [CW-1:0] RST_SLICE = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [CW-1:0] data_i,
    input  logic          gather_i,
    input  logic          clear_i,
    output logic          ready_o,
    output logic          accept_o,
    output logic          pending_o,
    output logic          pending_nxt_o,
    output logic [CW-1:0] shadow_nxt_o
);

    logic          pending_q, pending_d;
    logic [CW-1:0] shadow_q, shadow_d;

    // Ready is a function of registered state only.
    assign ready_o  = ATOMIC ? (gather_i & ~pending_q) : 1'b1;
    assign accept_o = valid_i & ready_o;

    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        // A clear (flush or handshake) drops any same-cycle write.
        if (accept_o && !clear_i) begin
            shadow_d = data_i;
        end
        if (!ATOMIC || clear_i) begin
            pending_d = 1'b0;
        end else if (accept_o) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            shadow_q  <= RST_SLICE;
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
        end
    end

    assign pending_o     = pending_q;
    assign pending_nxt_o = pending_d;
    assign shadow_nxt_o  = shadow_d;

endmodule

// File: rtl/packed_slice_gather.sv
// NCH lanes each own a CW-bit slice of a merged, registered output vector.
// MODE_IMMEDIATE publishes every write next cycle; MODE_ATOMIC publishes the
// whole vector once all lanes have written, with a valid/ready handshake.
// Ports: i_clk, i_rst (sync, active-high), i_valid/o_ready/i_data (lanes),
//        i_flush (abandon gather), o_valid/i_ready/o_data (consumer),
//        o_pending (per-lane written-since-publish flags).
module packed_slice_gather
    import packed_slice_pkg::*;
#(
    parameter int                  NCH       = 4,
    parameter int                  CW        = 4,
    parameter mode_e               MODE      = MODE_IMMEDIATE,
    parameter logic [NCH*CW-1:0]   RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NCH-1:0]    i_valid,
    output logic [NCH-1:0]    o_ready,
    input  logic [NCH*CW-1:0] i_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NCH*CW-1:0] o_data,
    output logic [NCH-1:0]    o_pending
);

    localparam bit ATOMIC = (MODE == MODE_ATOMIC);

    state_e            state_q;
    logic              valid_q;
    logic [NCH*CW-1:0] data_q;

    logic              gather;
    logic              clear;
    logic [NCH-1:0]    accept;
    logic [NCH-1:0]    pend_q;
    logic [NCH-1:0]    pend_nxt;
    logic [NCH*CW-1:0] merged_nxt;

    assign gather = (state_q == ST_GATHER);

    // Pending flags clear on a flush while gathering or on the handshake.
    assign clear = ATOMIC & ((gather & i_flush) | (~gather & valid_q & i_ready));

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        slice_lane #(
            .CW        (CW),
            .ATOMIC    (ATOMIC),
            .RST_SLICE (RESET_VAL[slice_lsb(k, CW) +: CW])
        ) u_lane (
            .clk_i         (i_clk),
            .rst_i         (i_rst),
            .valid_i       (i_valid[k]),
            .data_i        (i_data[slice_lsb(k, CW) +: CW]),
            .gather_i      (gather),
            .clear_i       (clear),
            .ready_o       (o_ready[k]),
            .accept_o      (accept[k]),
            .pending_o     (pend_q[k]),
            .pending_nxt_o (pend_nxt[k]),
            .shadow_nxt_o  (merged_nxt[slice_lsb(k, CW) +: CW])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_GATHER;
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else if (!ATOMIC) begin
            // Shadows track the output, so the merge is the next o_data.
            state_q <= ST_GATHER;
            valid_q <= |accept;
            data_q  <= merged_nxt;
        end else begin
            unique case (state_q)
                ST_GATHER: begin
                    // Includes lanes completing in this very cycle.
                    if (!i_flush && (&pend_nxt)) begin
                        state_q <= ST_PUBLISH;
                        valid_q <= 1'b1;
                        data_q  <= merged_nxt;
                    end
                end
                ST_PUBLISH: begin
                    if (i_ready) begin
                        state_q <= ST_GATHER;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_GATHER;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_pending = pend_q;

endmodule

// File: tb/tb_packed_slice_gather.sv
// Directed bench for packed_slice_gather: one immediate-mode and one
// atomic-mode instance on shared stimulus, atomic publishes via scoreboard.
module tb_packed_slice_gather;

    localparam int          NCH = 4;
    localparam int          CW  = 4;
    localparam logic [15:0] RV  = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic [15:0] dat;
    logic        flush;
    logic        rdy;

    logic [3:0]  m_ready, a_ready;
    logic        m_valid, a_valid;
    logic [15:0] m_data, a_data;
    logic [3:0]  m_pend, a_pend;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    packed_slice_gather #(
        .NCH(NCH), .CW(CW),
        .MODE(packed_slice_pkg::MODE_IMMEDIATE), .RESET_VAL(RV)
    ) u_imm (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(m_ready),
        .i_data(dat), .i_flush(flush), .o_valid(m_valid), .i_ready(rdy),
        .o_data(m_data), .o_pending(m_pend)
    );

    packed_slice_gather #(
        .NCH(NCH), .CW(CW),
        .MODE(packed_slice_pkg::MODE_ATOMIC), .RESET_VAL(RV)
    ) u_atm (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(a_ready),
        .i_data(dat), .i_flush(flush), .o_valid(a_valid), .i_ready(rdy),
        .o_data(a_data), .o_pending(a_pend)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] d);
        vld = v;
        dat = d;
        tick();
        vld = '0;
    endtask

    // Pop the next expected publish and complete the handshake with it.
    task automatic consume(input string tag);
        logic [15:0] exp;
        int n;
        n = 0;
        while (!a_valid && n < 20) begin
            tick();
            n++;
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        checks++;
        if (!a_valid) begin
            errors++;
            $error("FAIL %s no publish within budget, observed o_valid %b expected 1",
                   tag, a_valid);
        end else begin
            check({tag, "_data"}, a_data, exp);
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        vld   = '0;
        dat   = '0;
        flush = 1'b0;
        rdy   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_imm_data", m_data, RV);
        check("rst_imm_valid", m_valid, 0);
        check("rst_imm_ready", m_ready, 4'hF);
        check("rst_atm_data", a_data, RV);
        check("rst_atm_valid", a_valid, 0);
        check("rst_atm_ready", a_ready, 4'hF);
        check("rst_atm_pend", a_pend, 0);

        // Immediate mode: lanes 0 and 3 together; lanes 1,2 data ignored.
        drive(4'b1001, 16'hF770);
        check("imm_data", m_data, 16'hF5A0);
        check("imm_pulse", m_valid, 1);
        check("imm_pend", m_pend, 0);
        tick();
        check("imm_pulse_end", m_valid, 0);
        check("imm_hold", m_data, 16'hF5A0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Atomic: lanes 0..3 on separate cycles.
        drive(4'b0001, 16'h0001);
        check("atm_pend0", a_pend, 4'b0001);
        check("atm_rdy0", a_ready, 4'b1110);
        drive(4'b0010, 16'h0020);
        drive(4'b0100, 16'h0300);
        check("atm_novalid", a_valid, 0);
        check("atm_olddata", a_data, RV);
        sb_q.push_back(16'h4321);
        drive(4'b1000, 16'h4000);
        check("atm_valid", a_valid, 1);
        check("atm_pub_rdy", a_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("atm_hold_valid", a_valid, 1);
            check("atm_hold_data", a_data, 16'h4321);
        end
        consume("atm_pub1");
        check("atm_after_valid", a_valid, 0);
        check("atm_after_pend", a_pend, 0);
        check("atm_after_rdy", a_ready, 4'hF);

        // Atomic: second write to a pending lane stalls.
        drive(4'b0010, 16'h0070);
        vld = 4'b0010;
        dat = 16'h0090;
        #1;
        check("stall_rdy", a_ready, 4'b1101);
        tick();
        check("stall_pend", a_pend, 4'b0010);
        sb_q.push_back(16'hCB7A);
        vld = 4'b1111;
        dat = 16'hCB9A;
        tick();
        vld = 4'b0010;
        dat = 16'h0090;
        check("stall_pub_valid", a_valid, 1);
        consume("stall_pub");
        check("stall_clr_pend", a_pend, 0);
        tick();
        vld = '0;
        check("stall_late_pend", a_pend, 4'b0010);

        // Flush with a same-cycle lane2 write.
        drive(4'b0001, 16'h0005);
        check("fl_pend_pre", a_pend, 4'b0011);
        flush = 1'b1;
        drive(4'b0100, 16'h0600);
        flush = 1'b0;
        check("fl_pend", a_pend, 0);
        check("fl_data", a_data, 16'hCB7A);
        check("fl_valid", a_valid, 0);
        drive(4'b1011, 16'hD0EF);
        check("fl_drop_pend", a_pend, 4'b1011);
        check("fl_drop_valid", a_valid, 0);
        sb_q.push_back(16'hD8EF);
        drive(4'b0100, 16'h0800);
        consume("fl_pub");

        // Reset while publishing: the offer disappears.
        drive(4'b1111, 16'h1234);
        check("rp_valid", a_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rp_valid_clr", a_valid, 0);
        check("rp_data", a_data, RV);
        check("rp_pend", a_pend, 0);
        rdy = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        check("rp_no_pub", a_valid, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
